step_sequencer_gen: RTL and testbench
=====================================

// Module: step_sequencer_gen
// PURPOSE
//  Parametrised step sequencer, next generation of the 8-key toggle sequencer in the SaSS synth.
//  - Stores a programmable note per step, instead of a fixed note per step.
//  - Plays the steps in a loop at a programmable tempo, with a programmable gate length.
//  - Supports record/preview of steps while stopped.
//  - Output feeds the oscillator note input, in the same place as the old sequencer's note_sustain.
// PARAMETERS
//  NUM_STEPS  8   number of steps in the pattern (>=2)
//  NOTE_W     4   note code width; code 0 = rest/silence
//  TEMPO_W    22  tempo period counter width, in clk cycles
//  GATE_W     8   gate-length counter width, in clk cycles
//  IDX_W      $clog2(NUM_STEPS)  derived; do not override
// PORTS
//  clk           in   1          system clock (10 kHz)
//  n_rst         in   1          asynchronous reset, active-low
//  seq_en        in   1          sequencer mode enable (level)
//  play_toggle   in   1          1-cycle pulse; toggles PLAYING<->STOPPED
//  step_sel      in   IDX_W      step addressed by write/clear
//  step_write    in   1          1-cycle pulse; mem[step_sel] <= note_in
//  step_clear    in   1          1-cycle pulse; mem[step_sel] <= 0
//  note_in       in   NOTE_W     note to record
//  tempo_period  in   TEMPO_W    clk cycles per step
//  gate_len      in   GATE_W     clk cycles the note sounds per step
//  loop_len      in   IDX_W+1    active steps, 1..NUM_STEPS
//  note_out      out  NOTE_W     note to play; 0 = silent
//  note_valid    out  1          high when note_out != 0
//  beat_idx      out  IDX_W      current step index
//  step_led      out  NUM_STEPS  one-hot of beat_idx; all 0 when seq_en=0
//  playing       out  1          high in PLAYING
// BEHAVIOUR
//  Reset values:
//  - All outputs 0, state OFF, pattern memory all 0.
//  - Tempo, gate and step index counters all 0.
//  FSM states OFF, STOPPED, PLAYING:
//  - OFF->STOPPED when seq_en=1.
//  - Any state->OFF on seq_en=0 (synchronous). This zeroes index, counters and outputs; memory is retained.
//  - STOPPED<->PLAYING on play_toggle.
//  - Entering PLAYING restarts the tempo count and beat fires next cycle at beat_idx=0. Exception: resume-from-pause (STOPPED reached from PLAYING) keeps beat_idx.
//  Tempo:
//  - tempo counter counts 0..eff_period-1; beat pulse when it wraps.
//  - eff_period = max(tempo_period,1).
//  Step advance on beat:
//  - beat_idx <= (beat_idx+1 >= eff_loop) ? 0 : beat_idx+1.
//  - eff_loop = loop_len clamped to 1..NUM_STEPS.
//  - If loop_len shrinks below beat_idx+1, wrap to 0 at the next beat.
//  Gate:
//  - At beat, latch mem[new idx] into the note register and load the gate counter.
//  - note_out is registered: beat in cycle N -> note visible in N+1.
//  - note_out holds the latched note for gate_len cycles, then goes to 0.
//  - gate_len=0 or gate_len>=eff_period: note held until the next beat.
//  Record/preview:
//  - step_write in STOPPED writes mem and plays note_in as a preview for eff gate cycles.
//  - step_write in PLAYING writes mem silently; a write to the current step is heard at its next visit.
//  - step_write and step_clear in OFF are ignored.
//  Simultaneous events:
//  - step_write and step_clear together: clear wins.
//  - play_toggle and seq_en falling together: OFF wins.
//  - beat and write to the new index in the same cycle: the old value plays.
//  Width rules:
//  - Counters saturate-free, compare with >=.
//  - No arithmetic overflow beyond the declared widths.
// STRUCTURE
//  step_seq_pkg:
//  - seq_state_t enum {OFF, STOPPED, PLAYING}.
//  - Default constants for tempo_period (120 BPM @10 kHz = 5000) and gate_len.
//  Sub-module seq_tempo_gen:
//  - Tempo counter, restart input, beat pulse out.
//  - One instance.
//  Pattern memory:
//  - Flop array NUM_STEPS x NOTE_W, in-module.
// TESTING
//  1. Reset (n_rst=0) mid-PLAYING with mem programmed -> all outputs 0, state OFF, mem reads 0 after release.
//  2. Write steps 0..7 = 1..8, period=10, gate=4, loop=8, play -> note_out=1 for 4 cycles starting 1 cycle after beat, then 0; sequence 1..8 wraps to 1 after 80 cycles.
//  3. loop_len=3 while beat_idx=5 -> next beat beat_idx=0, then 0,1,2,0; step_led one-hot follows.
//  4. STOPPED, step_write sel=2 note=9, gate=4 -> note_out=9 for 4 cycles; PLAYING write sel=2 -> no preview, heard next visit.
//  5. tempo_period=0, gate=0 -> beat every cycle, note held, no hang.
//  6. write+clear same cycle sel=1 -> mem[1]=0; seq_en drop with play_toggle -> OFF, outputs 0.

Source files
------------

// File: rtl/step_seq_pkg.sv
// ============================================================================
// Module      : step_seq_pkg
// Description : Shared state type and default settings for the step sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package step_seq_pkg;

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        STOPPED = 2'd1,
        PLAYING = 2'd2
    } seq_state_t;

    // 120 BPM at a 10 kHz system clock
    localparam int unsigned c_DEF_TEMPO_PERIOD = 5000;
    localparam int unsigned c_DEF_GATE_LEN     = 250;

endpackage

`default_nettype wire

// File: rtl/seq_tempo_gen.sv
// ============================================================================
// Module      : seq_tempo_gen
// Description : Tempo counter; beat fires on the first enabled cycle after a
//               restart and then every eff_period cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_tempo_gen
    import step_seq_pkg::*;
#(
    parameter int TEMPO_W = 22
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               enable,
    input  logic               restart,
    input  logic [TEMPO_W-1:0] eff_period,
    output logic               beat
);

    localparam logic [TEMPO_W-1:0] c_ONE = TEMPO_W'(1);

    logic [TEMPO_W-1:0] r_cnt;
    logic               r_kick;

    // >= so a period shortened mid-count still wraps at once
    assign beat = enable && (r_kick || (r_cnt >= (eff_period - c_ONE)));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt  <= '0;
            r_kick <= 1'b0;
        end else if (restart) begin
            r_cnt  <= '0;
            r_kick <= 1'b1;
        end else if (!enable || beat) begin
            r_cnt  <= '0;
            r_kick <= 1'b0;
        end else begin
            r_cnt  <= r_cnt + c_ONE;
        end
    end

endmodule

`default_nettype wire

// File: rtl/step_sequencer_gen.sv
// ============================================================================
// Module      : step_sequencer_gen
// Description : Looping step sequencer with per-step note memory, tempo, gate
//               length and record/preview while stopped.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module step_sequencer_gen
    import step_seq_pkg::*;
#(
    parameter  int NUM_STEPS = 8,
    parameter  int NOTE_W    = 4,
    parameter  int TEMPO_W   = 22,
    parameter  int GATE_W    = 8,
    localparam int IDX_W     = $clog2(NUM_STEPS)
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 seq_en,
    input  logic                 play_toggle,
    input  logic [IDX_W-1:0]     step_sel,
    input  logic                 step_write,
    input  logic                 step_clear,
    input  logic [NOTE_W-1:0]    note_in,
    input  logic [TEMPO_W-1:0]   tempo_period,
    input  logic [GATE_W-1:0]    gate_len,
    input  logic [IDX_W:0]       loop_len,
    output logic [NOTE_W-1:0]    note_out,
    output logic                 note_valid,
    output logic [IDX_W-1:0]     beat_idx,
    output logic [NUM_STEPS-1:0] step_led,
    output logic                 playing
);

    localparam logic [IDX_W:0]     c_NUM_STEPS = (IDX_W+1)'(NUM_STEPS);
    localparam logic [IDX_W:0]     c_IDX_ONE   = (IDX_W+1)'(1);
    localparam logic [TEMPO_W-1:0] c_T_ONE     = TEMPO_W'(1);

    seq_state_t         r_state;
    seq_state_t         w_state_nxt;
    logic [NOTE_W-1:0]  r_mem [NUM_STEPS];
    logic [IDX_W-1:0]   r_idx;
    logic [NOTE_W-1:0]  r_note;
    logic [TEMPO_W-1:0] r_gate;
    logic               r_first;

    logic [TEMPO_W-1:0] w_eff_period;
    logic [TEMPO_W-1:0] w_gate_ext;
    logic [TEMPO_W-1:0] w_gate_load;
    logic [IDX_W:0]     w_eff_loop;
    logic [IDX_W:0]     w_idx_ext;
    logic [IDX_W:0]     w_idx_inc;
    logic [IDX_W-1:0]   w_idx_new;
    logic               w_beat;
    logic               w_enter;
    logic               w_sel_ok;
    logic               w_mem_we;
    logic               w_preview;
    logic               w_led_en;

    // ---------------- state machine ----------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!seq_en) begin
            w_state_nxt = OFF;
        end else begin
            case (r_state)
                OFF:     w_state_nxt = STOPPED;
                STOPPED: if (play_toggle) w_state_nxt = PLAYING;
                PLAYING: if (play_toggle) w_state_nxt = STOPPED;
                default: w_state_nxt = OFF;
            endcase
        end
    end

    // ---------------- effective settings ----------------
    assign w_eff_period = (tempo_period == '0) ? c_T_ONE : tempo_period;
    // Gate counter shares the tempo width so "hold until next beat" fits
    assign w_gate_ext   = TEMPO_W'(gate_len);
    assign w_gate_load  = ((gate_len == '0) || (w_gate_ext >= w_eff_period))
                        ? (w_eff_period - c_T_ONE) : (w_gate_ext - c_T_ONE);

    always_comb begin
        w_eff_loop = loop_len;
        if (loop_len == '0) begin
            w_eff_loop = c_IDX_ONE;
        end else if (loop_len > c_NUM_STEPS) begin
            w_eff_loop = c_NUM_STEPS;
        end
    end

    // First beat after entering PLAYING replays the kept index instead of advancing
    assign w_idx_ext = {1'b0, r_idx};
    assign w_idx_inc = w_idx_ext + c_IDX_ONE;
    always_comb begin
        w_idx_new = '0;
        if (r_first) begin
            if (w_idx_ext < w_eff_loop) w_idx_new = r_idx;
        end else begin
            if (w_idx_inc < w_eff_loop) w_idx_new = w_idx_inc[IDX_W-1:0];
        end
    end

    assign w_enter   = seq_en && (r_state == STOPPED) && play_toggle;
    assign w_sel_ok  = ({1'b0, step_sel} < c_NUM_STEPS);
    assign w_mem_we  = seq_en && (r_state != OFF) && (step_write || step_clear) && w_sel_ok;
    assign w_preview = seq_en && (r_state == STOPPED) && step_write && !step_clear && w_sel_ok;

    seq_tempo_gen #(
        .TEMPO_W    (TEMPO_W)
    ) u_tempo (
        .clk        (clk),
        .n_rst      (n_rst),
        .enable     (seq_en && (r_state == PLAYING)),
        .restart    (w_enter),
        .eff_period (w_eff_period),
        .beat       (w_beat)
    );

    // ---------------- pattern memory, note and gate ----------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_idx   <= '0;
            r_note  <= '0;
            r_gate  <= '0;
            r_first <= 1'b0;
            for (int i = 0; i < NUM_STEPS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (!seq_en) begin
            r_idx   <= '0;
            r_note  <= '0;
            r_gate  <= '0;
            r_first <= 1'b0;
        end else begin
            if (w_mem_we) begin
                r_mem[step_sel] <= step_clear ? '0 : note_in;
            end
            if (w_enter) begin
                r_first <= 1'b1;
            end
            // Memory is read before this cycle's write lands, so a same-cycle write plays next visit
            if (w_beat) begin
                r_idx   <= w_idx_new;
                r_note  <= r_mem[w_idx_new];
                r_gate  <= w_gate_load;
                r_first <= 1'b0;
            end else if (w_preview) begin
                r_note  <= note_in;
                r_gate  <= w_gate_load;
            end else if (r_gate != '0) begin
                r_gate  <= r_gate - c_T_ONE;
            end else begin
                r_note  <= '0;
            end
        end
    end

    // ---------------- outputs ----------------
    assign note_out   = r_note;
    assign note_valid = (r_note != '0);
    assign beat_idx   = r_idx;
    assign playing    = (r_state == PLAYING);
    assign w_led_en   = seq_en && (r_state != OFF);

    for (genvar g = 0; g < NUM_STEPS; g++) begin : g_led
        assign step_led[g] = w_led_en && (r_idx == IDX_W'(g));
    end

endmodule

`default_nettype wire

// File: tb/tb_step_sequencer_gen.sv
// ============================================================================
// Module      : tb_step_sequencer_gen
// Description : Directed and random checks of step_sequencer_gen against a
//               time-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_step_sequencer_gen;
    import step_seq_pkg::*;

    localparam int M_OFF  = 0;
    localparam int M_STOP = 1;
    localparam int M_PLAY = 2;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        seq_en;
    logic        play_toggle;
    logic [2:0]  step_sel;
    logic        step_write;
    logic        step_clear;
    logic [3:0]  note_in;
    logic [21:0] tempo_period;
    logic [7:0]  gate_len;
    logic [3:0]  loop_len;
    logic [3:0]  note_out;
    logic        note_valid;
    logic [2:0]  beat_idx;
    logic [7:0]  step_led;
    logic        playing;

    int tests = 0;
    int fails = 0;

    // model: absolute cycle time, beats derived from the play start time
    int m_t = 0;
    int m_mode = M_OFF;
    int m_idx = 0;
    int m_mem [8];
    int m_note_val = 0;
    int m_until = -1;
    int m_play_start = 0;

    step_sequencer_gen dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .seq_en       (seq_en),
        .play_toggle  (play_toggle),
        .step_sel     (step_sel),
        .step_write   (step_write),
        .step_clear   (step_clear),
        .note_in      (note_in),
        .tempo_period (tempo_period),
        .gate_len     (gate_len),
        .loop_len     (loop_len),
        .note_out     (note_out),
        .note_valid   (note_valid),
        .beat_idx     (beat_idx),
        .step_led     (step_led),
        .playing      (playing)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        int p, g, el, ni;
        bit beat;
        if (!n_rst) begin
            m_mode = M_OFF; m_idx = 0; m_note_val = 0; m_until = -1;
            for (int i = 0; i < 8; i++) m_mem[i] = 0;
            m_t++;
            return;
        end
        p  = (tempo_period == 0) ? 1 : int'(tempo_period);
        g  = (gate_len == 0 || int'(gate_len) >= p) ? p : int'(gate_len);
        el = (loop_len == 0) ? 1 : ((int'(loop_len) > 8) ? 8 : int'(loop_len));
        if (!seq_en) begin
            m_mode = M_OFF; m_idx = 0; m_note_val = 0; m_until = -1;
        end else begin
            beat = (m_mode == M_PLAY) && (((m_t - m_play_start) % p) == 0);
            if (beat) begin
                if (m_t == m_play_start) ni = (m_idx >= el) ? 0 : m_idx;
                else                     ni = (m_idx + 1 >= el) ? 0 : m_idx + 1;
                m_idx = ni;
                m_note_val = m_mem[ni];
                m_until = m_t + g;
            end else if (m_mode == M_STOP && step_write && !step_clear) begin
                m_note_val = int'(note_in);
                m_until = m_t + g;
            end
            if (m_mode != M_OFF) begin
                if (step_clear)      m_mem[step_sel] = 0;
                else if (step_write) m_mem[step_sel] = int'(note_in);
            end
            case (m_mode)
                M_OFF:  m_mode = M_STOP;
                M_STOP: if (play_toggle) begin m_mode = M_PLAY; m_play_start = m_t + 1; end
                default: if (play_toggle) m_mode = M_STOP;
            endcase
        end
        m_t++;
    endtask

    task automatic check_cycle();
        int en, eled, eplay;
        en    = (m_t <= m_until) ? m_note_val : 0;
        eled  = (seq_en && m_mode != M_OFF) ? (1 << m_idx) : 0;
        eplay = (m_mode == M_PLAY) ? 1 : 0;
        tests++;
        if (note_out !== 4'(en) || note_valid !== (en != 0) || beat_idx !== 3'(m_idx)
            || step_led !== 8'(eled) || playing !== eplay[0]) begin
            fails++;
            $display("FAIL cycle %0d: note=%0d/%0d valid=%0b idx=%0d/%0d led=%b/%b play=%0b/%0d",
                     m_t, note_out, en, note_valid, beat_idx, m_idx, step_led, 8'(eled), playing, eplay);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic lit(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic pulse_toggle();
        play_toggle = 1'b1; tick(); play_toggle = 1'b0;
    endtask

    task automatic write_step(input int sel, input int note);
        step_sel = 3'(sel); note_in = 4'(note); step_write = 1'b1;
        tick();
        step_write = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0; seq_en = 1'b0; play_toggle = 1'b0; step_sel = '0;
        step_write = 1'b0; step_clear = 1'b0; note_in = '0;
        tempo_period = 22'(c_DEF_TEMPO_PERIOD); gate_len = 8'(c_DEF_GATE_LEN); loop_len = 4'd8;
        for (int i = 0; i < 8; i++) m_mem[i] = 0;
        @(negedge clk);
        lit("reset note_out", int'(note_out), 0);
        lit("reset playing", int'(playing), 0);
        lit("reset step_led", int'(step_led), 0);
        run(2);
        n_rst = 1'b1; seq_en = 1'b1;
        tick();

        // program 1..8, period 10, gate 4, loop 8
        tempo_period = 22'd10; gate_len = 8'd4; loop_len = 4'd8;
        for (int i = 0; i < 8; i++) write_step(i, i + 1);
        run(6);
        pulse_toggle();                                  // k=0: first beat
        run(1);  lit("play k1 note", int'(note_out), 1);
        run(3);  lit("play k4 note", int'(note_out), 1);
        run(1);  lit("play k5 gate off", int'(note_out), 0);
        run(6);  lit("play k11 note", int'(note_out), 2);
                 lit("play k11 idx", int'(beat_idx), 1);
        run(70); lit("wrap k81 note", int'(note_out), 1);
                 lit("wrap k81 idx", int'(beat_idx), 0);

        // shrink loop while on step 5
        run(54); lit("k135 idx", int'(beat_idx), 5);
        loop_len = 4'd3;
        run(6);  lit("shrink idx", int'(beat_idx), 0);
                 lit("shrink led", int'(step_led), 1);
        run(1);  lit("shrink note", int'(note_out), 1);
        run(9);  lit("loop3 led1", int'(step_led), 2);
        run(10); lit("loop3 led2", int'(step_led), 4);
        run(10); lit("loop3 wrap idx", int'(beat_idx), 0);

        // preview while stopped, silent write while playing
        pulse_toggle();
        run(5);
        loop_len = 4'd8;
        write_step(2, 9);
        lit("preview c1", int'(note_out), 9);
        run(3);  lit("preview c4", int'(note_out), 9);
        run(1);  lit("preview c5 off", int'(note_out), 0);
        pulse_toggle();                                  // resume at idx 0
        run(5);
        write_step(2, 5);
        run(1);  lit("silent write", int'(note_out), 0);
        run(14); lit("heard next visit", int'(note_out), 5);
                 lit("visit idx", int'(beat_idx), 2);

        // period 0, gate 0: beat every cycle, resume keeps idx 2
        pulse_toggle();
        tempo_period = 22'd0; gate_len = 8'd0;
        run(2);
        pulse_toggle();
        run(1);  lit("fast k1 note", int'(note_out), 5);
        run(6);  lit("fast k7 note", int'(note_out), 1);

        // write+clear on step 1, then seq_en drop with toggle
        pulse_toggle();                                  // paused at idx 1
        step_sel = 3'd1; note_in = 4'd7; step_write = 1'b1; step_clear = 1'b1;
        tick();
        step_write = 1'b0; step_clear = 1'b0;
        lit("clear no preview", int'(note_out), 0);
        pulse_toggle();
        run(1);  lit("cleared step", int'(note_out), 0);
                 lit("cleared idx", int'(beat_idx), 1);
        seq_en = 1'b0; play_toggle = 1'b1;
        tick();
        play_toggle = 1'b0;
        lit("drop playing", int'(playing), 0);
        lit("drop led", int'(step_led), 0);

        // async reset mid-play clears memory
        seq_en = 1'b1; tick();
        tempo_period = 22'd3; gate_len = 8'd2;
        pulse_toggle();
        run(7);
        #2 n_rst = 1'b0;
        #1;
        lit("async rst note", int'(note_out), 0);
        lit("async rst playing", int'(playing), 0);
        lit("async rst idx", int'(beat_idx), 0);
        tick();
        n_rst = 1'b1;
        tick();
        tempo_period = 22'd0; gate_len = 8'd0;
        run(1);
        pulse_toggle();
        run(3);  lit("mem zero after rst", int'(note_out), 0);

        // random stimulus
        for (int i = 0; i < 4000; i++) begin
            seq_en      = ($urandom_range(0, 149) != 0);
            play_toggle = ($urandom_range(0, 14) == 0);
            step_write  = ($urandom_range(0, 7) == 0);
            step_clear  = ($urandom_range(0, 19) == 0);
            step_sel    = 3'($urandom_range(0, 7));
            note_in     = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) loop_len = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) gate_len = 8'($urandom_range(0, 15));
            if (m_mode != M_PLAY && $urandom_range(0, 9) == 0)
                tempo_period = 22'($urandom_range(0, 12));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
